// File: rtl/dot16_feeder.sv
// dot16_feeder
// Issue-side controller for the 16-lane dot-product datapath inside a PE row.
// Takes paired A/B vector chunks over a valid/ready handshake and issues each
// chunk to the dot unit with an accumulator seed. It then waits for the
// matching partial sum and uses it as the seed for the next chunk. When the
// final chunk of a K-length reduction completes, the result is presented on a
// valid/ready output port.
//
// The dot unit free-runs (dot_ena held high), so every non-issue cycle drives
// zero operands and a zero seed.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   vec_valid/ready     chunk handshake; vec_a/vec_b packed lanes, vec_last
//   dot_ena             datapath enable (1 from the first clock after reset)
//   dot_a/dot_b/dot_acc operands and accumulator seed to the dot unit
//   dot_result          partial sum returned by the dot unit
//   out_valid/ready     final result handshake; out_data signed result
//   perf_chunks         (DOT16_FEEDER_PERF_EN only) chunks accepted
//   perf_stall          (DOT16_FEEDER_PERF_EN only) cycles vec_valid & !vec_ready
//
// Build option
//   DOT16_FEEDER_PERF_EN : adds the two 32-bit wrapping performance counters.
//
// States
//   IDLE | ready for a chunk, operands held at zero
//   WAIT | chunk in flight in the dot unit, counting down to its result
//   DONE | final result presented, waiting for out_ready

module dot16_feeder #(
    parameter int DATA_WIDTH    = 16,
    parameter int VECTOR_LENGTH = 16,
    parameter int ACCU_WIDTH    = 32,
    parameter int DOT_LATENCY   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                vec_valid,
    output logic                                vec_ready,
    input  logic [DATA_WIDTH*VECTOR_LENGTH-1:0] vec_a,
    input  logic [DATA_WIDTH*VECTOR_LENGTH-1:0] vec_b,
    input  logic                                vec_last,
    output logic                                dot_ena,
    output logic [DATA_WIDTH*VECTOR_LENGTH-1:0] dot_a,
    output logic [DATA_WIDTH*VECTOR_LENGTH-1:0] dot_b,
    output logic [ACCU_WIDTH-1:0]               dot_acc,
    input  logic [ACCU_WIDTH-1:0]               dot_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACCU_WIDTH-1:0]               out_data
`ifdef DOT16_FEEDER_PERF_EN
    ,
    output logic [31:0]                         perf_chunks,
    output logic [31:0]                         perf_stall
`endif
);

    localparam int VEC_W = DATA_WIDTH * VECTOR_LENGTH;
    localparam int CNT_W = (DOT_LATENCY > 1) ? $clog2(DOT_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOT_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  vec_ready_q, vec_ready_d;
    logic                  dot_ena_q, dot_ena_d;
    logic [VEC_W-1:0]      dot_a_q, dot_a_d;
    logic [VEC_W-1:0]      dot_b_q, dot_b_d;
    logic [ACCU_WIDTH-1:0] dot_acc_q, dot_acc_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACCU_WIDTH-1:0] out_data_q, out_data_d;
    logic [ACCU_WIDTH-1:0] acc_hold_q, acc_hold_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept;

    // vec_ready is registered, so the handshake is judged on the flop value.
    assign accept = vec_valid & vec_ready_q;

    always_comb begin
        state_d     = state_q;
        dot_ena_d   = 1'b1;
        // Bubble cycles feed zeros into the free-running datapath.
        dot_a_d     = '0;
        dot_b_d     = '0;
        dot_acc_d   = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_hold_d  = acc_hold_q;
        first_d     = first_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dot_a_d   = vec_a;
                    dot_b_d   = vec_b;
                    dot_acc_d = first_q ? '0 : acc_hold_q;
                    last_d    = vec_last;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_hold_d = dot_result;
                    if (last_q) begin
                        out_data_d  = dot_result;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        first_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    first_d     = 1'b1;
                    acc_hold_d  = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready follows the state being entered so it is glitch-free and
        // still reads 0 while in reset.
        vec_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_ready_q <= 1'b0;
            dot_ena_q   <= 1'b0;
            dot_a_q     <= '0;
            dot_b_q     <= '0;
            dot_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_hold_q  <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_ready_q <= vec_ready_d;
            dot_ena_q   <= dot_ena_d;
            dot_a_q     <= dot_a_d;
            dot_b_q     <= dot_b_d;
            dot_acc_q   <= dot_acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_hold_q  <= acc_hold_d;
            first_q     <= first_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign vec_ready = vec_ready_q;
    assign dot_ena   = dot_ena_q;
    assign dot_a     = dot_a_q;
    assign dot_b     = dot_b_q;
    assign dot_acc   = dot_acc_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef DOT16_FEEDER_PERF_EN
    logic [31:0] perf_chunks_q, perf_chunks_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_chunks_d = perf_chunks_q;
        perf_stall_d  = perf_stall_q;
        if (accept) begin
            perf_chunks_d = perf_chunks_q + 32'd1;
        end
        if (vec_valid && !vec_ready_q) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_chunks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_chunks_q <= perf_chunks_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_chunks = perf_chunks_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_dot16_feeder.sv
module tb_dot16_feeder;

    localparam int DW  = 16;
    localparam int VL  = 16;
    localparam int AW  = 32;
    localparam int LAT = 8;
    localparam int VW  = DW * VL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vec_valid;
    logic          vec_ready;
    logic [VW-1:0] vec_a;
    logic [VW-1:0] vec_b;
    logic          vec_last;
    logic          dot_ena;
    logic [VW-1:0] dot_a;
    logic [VW-1:0] dot_b;
    logic [AW-1:0] dot_acc;
    logic [AW-1:0] dot_result;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
`ifdef DOT16_FEEDER_PERF_EN
    logic [31:0]   perf_chunks;
    logic [31:0]   perf_stall;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dot16_feeder #(
        .DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .ACCU_WIDTH(AW), .DOT_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_a(vec_a), .vec_b(vec_b), .vec_last(vec_last),
        .dot_ena(dot_ena), .dot_a(dot_a), .dot_b(dot_b), .dot_acc(dot_acc),
        .dot_result(dot_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef DOT16_FEEDER_PERF_EN
        , .perf_chunks(perf_chunks), .perf_stall(perf_stall)
`endif
    );

    // Behavioural dot unit: signed lane products summed with the seed, result
    // appearing LAT cycles after the operands were registered by the feeder.
    // It is never reset, so stale in-flight results keep arriving.
    logic [AW-1:0] dot_comb;
    logic [AW-1:0] pipe [LAT-1];
    int            prod;

    always_comb begin
        dot_comb = dot_acc;
        prod     = 0;
        for (int i = 0; i < VL; i++) begin
            prod     = int'($signed(dot_a[DW*i +: DW])) * int'($signed(dot_b[DW*i +: DW]));
            dot_comb = dot_comb + AW'(prod);
        end
    end

    always_ff @(posedge clk) begin
        pipe[0] <= dot_comb;
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end

    assign dot_result = pipe[LAT-2];

    function automatic logic [VW-1:0] rep(input logic [DW-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < VL; i++) r[DW*i +: DW] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one chunk and follow it to completion. Checks issue operands,
    // the bubble, the issue-to-ready/valid latency and the final result.
    task automatic send_chunk(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                              input logic last, input logic [AW-1:0] exp_acc,
                              input logic [AW-1:0] exp_out, input string tag);
        int k;
        @(negedge clk);
        vec_a = rep(av); vec_b = rep(bv); vec_last = last; vec_valid = 1'b1;
        k = 0;
        while (!vec_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, VW'(vec_ready), VW'(1));
        @(posedge clk); #1;
        vec_valid = 1'b0;
        chk({tag, "_dot_a"}, dot_a, rep(av));
        chk({tag, "_dot_b"}, dot_b, rep(bv));
        chk({tag, "_dot_acc"}, VW'(dot_acc), VW'(exp_acc));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) chk({tag, "_ready_low"}, VW'(vec_ready), VW'(0));
            if (k == 2) chk({tag, "_bubble"}, {dot_a[VW-1:AW], dot_acc} | dot_b, '0);
        end while (!(last ? out_valid : vec_ready) && k < 40);
        chk({tag, "_latency"}, VW'(k), VW'(LAT + 1));
        if (last) begin
            chk({tag, "_out_data"}, VW'(out_data), VW'(exp_out));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tag, "_out_clear"}, VW'(out_valid), VW'(0));
        end
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
        logic [AW-1:0] acc;
        logic [AW-1:0] out;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int k;

        tbl[0] = '{16'h0001, 16'h0002, 1'b1, 32'h0000_0000, 32'h0000_0020};
        tbl[1] = '{16'h0001, 16'h0002, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[2] = '{16'h0001, 16'h0002, 1'b1, 32'h0000_0020, 32'h0000_0040};
        tbl[3] = '{16'hFFFF, 16'h0003, 1'b1, 32'h0000_0000, 32'hFFFF_FFD0};
        tbl[4] = '{16'h7FFF, 16'h7FFF, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[5] = '{16'h8000, 16'h8000, 1'b1, 32'hFFF0_0010, 32'hFFF0_0010};
        tbl[6] = '{16'h0002, 16'hFFFE, 1'b1, 32'h0000_0000, 32'hFFFF_FFC0};

        rst_n = 1'b0; vec_valid = 1'b0; vec_a = '0; vec_b = '0;
        vec_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec_ready", VW'(vec_ready), VW'(0));
        chk("rst_dot_ena", VW'(dot_ena), VW'(0));
        chk("rst_dot_ops", dot_a | dot_b | VW'(dot_acc), '0);
        chk("rst_out", VW'({out_valid, out_data}), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ena_after_rst", VW'(dot_ena), VW'(1));
        chk("ready_after_rst", VW'(vec_ready), VW'(1));

        for (int i = 0; i < 7; i++) begin
            send_chunk(tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].acc, tbl[i].out,
                       $sformatf("vec%0d", i));
        end

        // Result held in DONE while the source keeps offering a chunk.
        @(negedge clk);
        vec_a = rep(16'h0001); vec_b = rep(16'h0002); vec_last = 1'b1; vec_valid = 1'b1;
        @(posedge clk); #1;
        vec_a = rep(16'h0003); vec_b = rep(16'h0001);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("hold_reach_done", VW'(out_valid), VW'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold_valid%0d", i), VW'(out_valid), VW'(1));
            chk($sformatf("hold_data%0d", i), VW'(out_data), VW'(32'h20));
            chk($sformatf("hold_noready%0d", i), VW'(vec_ready), VW'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_released", VW'(out_valid), VW'(0));
        chk("hold_no_accept", dot_a, '0);
        chk("hold_ready_next", VW'(vec_ready), VW'(1));
        @(posedge clk); #1;
        vec_valid = 1'b0;
        chk("post_hold_dot_a", dot_a, rep(16'h0003));
        chk("post_hold_acc", VW'(dot_acc), VW'(0));

        // out_ready already high when out_valid rises: one-cycle DONE.
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("same_cycle_data", VW'(out_data), VW'(32'h30));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("same_cycle_clear", VW'(out_valid), VW'(0));
        @(negedge clk);
        chk("same_cycle_ready", VW'(vec_ready), VW'(1));

        // Reset in the middle of a second chunk's WAIT (cnt==3).
        send_chunk(16'h0001, 16'h0002, 1'b0, 32'h0, 32'h0, "pre_rst");
        @(negedge clk);
        vec_a = rep(16'h0001); vec_b = rep(16'h0002); vec_last = 1'b1; vec_valid = 1'b1;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        chk("mid_rst_issue_acc", VW'(dot_acc), VW'(32'h20));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", VW'(vec_ready), VW'(0));
        chk("mid_rst_ena", VW'(dot_ena), VW'(0));
        chk("mid_rst_ops", dot_a | dot_b | VW'(dot_acc), '0);
        chk("mid_rst_out", VW'({out_valid, out_data}), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send_chunk(16'h0001, 16'h0001, 1'b1, 32'h0, 32'h10, "post_rst");

`ifdef DOT16_FEEDER_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("perf_rst", VW'({perf_chunks, perf_stall}), VW'(0));
        vec_a = rep(16'h0001); vec_b = rep(16'h0001); vec_last = 1'b0; vec_valid = 1'b1;
        k = 0;
        for (int n = 0; n < 3; n++) begin
            while (!vec_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            vec_last = (n == 2);
            @(posedge clk); #1;
        end
        vec_valid = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        out_ready = 1'b0;
        chk("perf_chunks", VW'(perf_chunks), VW'(3));
        chk("perf_stall", VW'(perf_stall), VW'(2 * LAT));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
